icache_mshr_entry_nline: RTL and testbench
==========================================

Name: icache_mshr_entry_nline

Overview:
Single MSHR entry generalised from a fixed A/B line pair to LINE_NUM sub-lines per request. It holds one fetch request and tracks per-line hit/miss and per-line hazards against other entries. It issues downstream linefills for missing lines in ascending line order and issues one combined data-RAM read when all lines are resident. It then pulses a release to the other entries. Instantiated ENTRY_NUM times inside the icache MSHR, between tag-check and the dataram/downstream arbiters.

Parameters:
ENTRY_NUM, 8, number of MSHR entries (hazard bitmap width)
ENTRY_ID, 0, index of this entry; own bit is ignored in hazard bitmaps
LINE_NUM, 2, sub-lines per request (min 1, max 4)
WAY_NUM, 4, cache ways; WAY_W = $clog2(WAY_NUM)
INDEX_W, 8, set index width
TXNID_W, 6, transaction id width
ADDR_W, 32, line address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_en  in  1  allocate this entry (honoured only in IDLE)
alloc_rdy  out  1  entry is IDLE and can accept alloc_en
alloc_line_vld  in  LINE_NUM  sub-line participates in request
alloc_hit  in  LINE_NUM  per-line tag hit
alloc_way  in  LINE_NUM*WAY_W  per-line dest way (hit way or victim)
alloc_addr  in  LINE_NUM*ADDR_W  per-line line address (index = low INDEX_W bits above offset, taken by caller)
alloc_index  in  LINE_NUM*INDEX_W  per-line set index
alloc_txnid  in  TXNID_W  upstream transaction id
alloc_pref  in  1  prefetch: fill only, no data-RAM read
alloc_hzd_bitmap  in  LINE_NUM*ENTRY_NUM  per-line older entries this line depends on
v_release_en  in  ENTRY_NUM  release pulses from all entries
entry_active  out  1  entry is not IDLE
txreq_vld  out  1  downstream linefill request
txreq_rdy  in  1  downstream accept
txreq_line  out  $clog2(LINE_NUM)+1  sub-line id being requested
txreq_addr  out  ADDR_W  line address of the request
txreq_txnid  out  TXNID_W  copy of stored txnid
linefill_done  in  LINE_NUM  per-line fill written to data RAM (1-cycle pulse)
rd_vld  out  1  data-RAM read request (all valid lines)
rd_rdy  in  1  data-RAM read accept
rd_line_vld  out  LINE_NUM  lines to read
rd_way  out  LINE_NUM*WAY_W  per-line way
rd_index  out  LINE_NUM*INDEX_W  per-line index
rd_txnid  out  TXNID_W  stored txnid
release_en  out  1  1-cycle release pulse to other entries
fill_err  out  1  sticky: linefill_done for a line with no outstanding request

Behaviour:
- Reset: FSM=IDLE. All storage is 0. alloc_rdy=1. entry_active, txreq_vld, rd_vld, release_en and fill_err are 0.
- States: IDLE, WAIT_HZD, REQ, WAIT_FILL, READ, RELEASE. One encoded FSM.
- IDLE: on alloc_en, latch all alloc_* fields into registers. Set miss[i]=line_vld[i]&~hit[i] and hzd[i]=alloc_hzd_bitmap[i] with the ENTRY_ID bit forced 0 and the current-cycle v_release_en masked off. Go to WAIT_HZD. entry_active=1 from the next cycle.
- Every cycle outside IDLE: hzd[i] <= hzd[i] & ~v_release_en. A line is free when |hzd[i]==0 or line_vld[i]==0.
- WAIT_HZD: when all lines are free, go to REQ if any miss is pending, else READ. If prefetch with no miss, go straight to RELEASE. Minimum one cycle in WAIT_HZD.
- REQ: txreq_vld=1 for the lowest i with miss[i]&~sent[i]; txreq_line/addr are that line's values. txreq_vld stays asserted and the payload stays stable until txreq_rdy. On handshake set sent[i]. When all missing lines are sent, go to WAIT_FILL in the same cycle as the last handshake. Issue rate is at most one request per cycle, so back-to-back handshakes are allowed.
- linefill_done[i] with sent[i]=1 sets filled[i], in any state (it may arrive while still in REQ). Order of arrival is arbitrary. A done in the same cycle as the handshake of the same line also counts.
- linefill_done[i] without an outstanding request: ignored, and fill_err is set (cleared only by reset).
- WAIT_FILL: when filled==miss, go to READ (or to RELEASE if prefetch).
- READ: rd_vld=1 with rd_line_vld=line_vld. Hold until rd_rdy, then go to RELEASE. All lines are read in one handshake.
- RELEASE: release_en=1 for exactly one cycle, then IDLE. alloc_rdy=1 again the cycle after. Back-to-back reallocation is allowed: release cycle N, alloc cycle N+1.
- txreq_vld and rd_vld are never asserted together.
- Asynchronous reset mid-operation discards the entry with no release pulse. The owner must reset all entries together.

Decomposition:
- Shared package toy_pack gets mshr_nline_state_e (6-state enum) and the LINE_NUM/WAY_W/INDEX_W/TXNID_W constants used by the MSHR top.
- Optional sub-module icache_mshr_hzd_track: per-line bitmap register with release masking and a free flag. It is instantiated LINE_NUM times.

Test Plan:
1. LINE_NUM=2, both hit, no hazard -> WAIT_HZD 1 cycle, rd_vld cycle 2, rd_rdy=1 -> release_en cycle 3 only, alloc_rdy cycle 4.
2. Line0 miss, line1 hit, hzd line0 = bit3 -> no txreq until v_release_en[3]. Then txreq_line=0 and addr=line0 address. After linefill_done[0], rd_vld with rd_line_vld=2'b11.
3. Both miss, txreq_rdy=0 for 3 cycles -> line0 payload held stable, then line1 issued next cycle. Done for line1 arrives before line0 -> READ only after both.
4. Prefetch, both miss -> two txreqs and two dones, no rd_vld, release_en pulses once.
5. linefill_done[1] while line1 not sent -> fill_err=1 and the entry waits normally.
6. Assert rst_n=0 while in WAIT_FILL -> all outputs drop to reset values asynchronously and release_en stays 0.

Source files
------------

// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared MSHR state encoding and default geometry constants
package toy_pack;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HZD,
    S_REQ,
    S_WAIT_FILL,
    S_READ,
    S_RELEASE
  } mshr_nline_state_e;

  localparam int MSHR_LINE_NUM = 2;
  localparam int MSHR_WAY_NUM  = 4;
  localparam int MSHR_WAY_W    = $clog2(MSHR_WAY_NUM);
  localparam int MSHR_INDEX_W  = 8;
  localparam int MSHR_TXNID_W  = 6;

endpackage

// File: rtl/icache_mshr_hzd_track.sv
// rtl/icache_mshr_hzd_track.sv - per-line hazard bitmap, cleared by release pulses
module icache_mshr_hzd_track #(
  parameter int ENTRY_NUM = 8,
  parameter int ENTRY_ID  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ENTRY_NUM-1:0] load_bitmap,
  input  logic [ENTRY_NUM-1:0] rel_vec,
  input  logic                 line_vld,
  output logic                 free
);

  logic [ENTRY_NUM-1:0] bitmap_q;
  logic [ENTRY_NUM-1:0] own_mask;

  always_comb begin
    own_mask           = '0;
    own_mask[ENTRY_ID] = 1'b1;
  end

  // A release landing in the allocation cycle must not leave a stale dependency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q <= '0;
    end else if (load) begin
      bitmap_q <= load_bitmap & ~own_mask & ~rel_vec;
    end else begin
      bitmap_q <= bitmap_q & ~rel_vec;
    end
  end

  assign free = ~(|bitmap_q) | ~line_vld;

endmodule

// File: rtl/icache_mshr_entry_nline.sv
// rtl/icache_mshr_entry_nline.sv - one icache MSHR entry tracking LINE_NUM sub-lines
module icache_mshr_entry_nline
  import toy_pack::*;
#(
  parameter int ENTRY_NUM = 8,
  parameter int ENTRY_ID  = 0,
  parameter int LINE_NUM  = MSHR_LINE_NUM,
  parameter int WAY_NUM   = MSHR_WAY_NUM,
  parameter int INDEX_W   = MSHR_INDEX_W,
  parameter int TXNID_W   = MSHR_TXNID_W,
  parameter int ADDR_W    = 32,
  localparam int WAY_W    = $clog2(WAY_NUM),
  localparam int LINE_W   = $clog2(LINE_NUM) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_en,
  output logic                          alloc_rdy,
  input  logic [LINE_NUM-1:0]           alloc_line_vld,
  input  logic [LINE_NUM-1:0]           alloc_hit,
  input  logic [LINE_NUM*WAY_W-1:0]     alloc_way,
  input  logic [LINE_NUM*ADDR_W-1:0]    alloc_addr,
  input  logic [LINE_NUM*INDEX_W-1:0]   alloc_index,
  input  logic [TXNID_W-1:0]            alloc_txnid,
  input  logic                          alloc_pref,
  input  logic [LINE_NUM*ENTRY_NUM-1:0] alloc_hzd_bitmap,
  input  logic [ENTRY_NUM-1:0]          v_release_en,
  output logic                          entry_active,
  output logic                          txreq_vld,
  input  logic                          txreq_rdy,
  output logic [LINE_W-1:0]             txreq_line,
  output logic [ADDR_W-1:0]             txreq_addr,
  output logic [TXNID_W-1:0]            txreq_txnid,
  input  logic [LINE_NUM-1:0]           linefill_done,
  output logic                          rd_vld,
  input  logic                          rd_rdy,
  output logic [LINE_NUM-1:0]           rd_line_vld,
  output logic [LINE_NUM*WAY_W-1:0]     rd_way,
  output logic [LINE_NUM*INDEX_W-1:0]   rd_index,
  output logic [TXNID_W-1:0]            rd_txnid,
  output logic                          release_en,
  output logic                          fill_err
);

  mshr_nline_state_e state_q, state_d;

  logic [LINE_NUM-1:0]         line_vld_q, miss_q, sent_q, filled_q;
  logic [LINE_NUM*WAY_W-1:0]   way_q;
  logic [LINE_NUM*ADDR_W-1:0]  addr_q;
  logic [LINE_NUM*INDEX_W-1:0] index_q;
  logic [TXNID_W-1:0]          txnid_q;
  logic                        pref_q, fill_err_q;

  logic [LINE_NUM-1:0] line_free, pending, req_sel, sent_set, fill_hit;
  logic                alloc_fire, txreq_fire, fill_bad, found;

  assign alloc_fire = alloc_en && (state_q == S_IDLE);
  assign pending    = miss_q & ~sent_q;

  for (genvar g = 0; g < LINE_NUM; g++) begin : g_hzd
    icache_mshr_hzd_track #(
      .ENTRY_NUM (ENTRY_NUM),
      .ENTRY_ID  (ENTRY_ID)
    ) u_hzd (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (alloc_fire),
      .load_bitmap (alloc_hzd_bitmap[g*ENTRY_NUM +: ENTRY_NUM]),
      .rel_vec     (v_release_en),
      .line_vld    (line_vld_q[g]),
      .free        (line_free[g])
    );
  end

  // Lowest-numbered unsent miss owns the request channel.
  always_comb begin
    req_sel    = '0;
    txreq_line = '0;
    txreq_addr = '0;
    found      = 1'b0;
    for (int i = 0; i < LINE_NUM; i++) begin
      if (pending[i] && !found) begin
        found      = 1'b1;
        req_sel[i] = 1'b1;
        txreq_line = LINE_W'(i);
        txreq_addr = addr_q[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign txreq_vld  = (state_q == S_REQ) && (|pending);
  assign txreq_fire = txreq_vld && txreq_rdy;
  assign sent_set   = txreq_fire ? req_sel : '0;
  // A done coinciding with its own request handshake still counts as a fill.
  assign fill_hit   = linefill_done & (sent_q | sent_set);
  assign fill_bad   = |(linefill_done & ~(sent_q | sent_set));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (alloc_en) state_d = S_WAIT_HZD;
      S_WAIT_HZD: begin
        if (&line_free) begin
          if (|miss_q)     state_d = S_REQ;
          else if (pref_q) state_d = S_RELEASE;
          else             state_d = S_READ;
        end
      end
      S_REQ:       if ((pending & ~sent_set) == '0) state_d = S_WAIT_FILL;
      S_WAIT_FILL: if (filled_q == miss_q) state_d = pref_q ? S_RELEASE : S_READ;
      S_READ:      if (rd_rdy) state_d = S_RELEASE;
      S_RELEASE:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_vld_q <= '0;
      miss_q     <= '0;
      sent_q     <= '0;
      filled_q   <= '0;
      way_q      <= '0;
      addr_q     <= '0;
      index_q    <= '0;
      txnid_q    <= '0;
      pref_q     <= 1'b0;
      fill_err_q <= 1'b0;
    end else begin
      fill_err_q <= fill_err_q | fill_bad;
      if (alloc_fire) begin
        line_vld_q <= alloc_line_vld;
        miss_q     <= alloc_line_vld & ~alloc_hit;
        way_q      <= alloc_way;
        addr_q     <= alloc_addr;
        index_q    <= alloc_index;
        txnid_q    <= alloc_txnid;
        pref_q     <= alloc_pref;
        sent_q     <= '0;
        filled_q   <= '0;
      end else if (state_q == S_RELEASE) begin
        sent_q   <= '0;
        filled_q <= '0;
      end else begin
        sent_q   <= sent_q | sent_set;
        filled_q <= filled_q | fill_hit;
      end
    end
  end

  assign alloc_rdy    = (state_q == S_IDLE);
  assign entry_active = (state_q != S_IDLE);
  assign rd_vld       = (state_q == S_READ);
  assign release_en   = (state_q == S_RELEASE);
  assign rd_line_vld  = line_vld_q;
  assign rd_way       = way_q;
  assign rd_index     = index_q;
  assign rd_txnid     = txnid_q;
  assign txreq_txnid  = txnid_q;
  assign fill_err     = fill_err_q;

endmodule

// File: tb/tb_icache_mshr_entry_nline.sv
// tb/tb_icache_mshr_entry_nline.sv - directed self-checking bench for icache_mshr_entry_nline
module tb_icache_mshr_entry_nline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_en;
  logic        alloc_rdy;
  logic [1:0]  alloc_line_vld;
  logic [1:0]  alloc_hit;
  logic [3:0]  alloc_way;
  logic [63:0] alloc_addr;
  logic [15:0] alloc_index;
  logic [5:0]  alloc_txnid;
  logic        alloc_pref;
  logic [15:0] alloc_hzd_bitmap;
  logic [7:0]  v_release_en;
  logic        entry_active;
  logic        txreq_vld;
  logic        txreq_rdy;
  logic [1:0]  txreq_line;
  logic [31:0] txreq_addr;
  logic [5:0]  txreq_txnid;
  logic [1:0]  linefill_done;
  logic        rd_vld;
  logic        rd_rdy;
  logic [1:0]  rd_line_vld;
  logic [3:0]  rd_way;
  logic [15:0] rd_index;
  logic [5:0]  rd_txnid;
  logic        release_en;
  logic        fill_err;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h1000_0080;

  always #5 clk = ~clk;

  icache_mshr_entry_nline dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_en         (alloc_en),
    .alloc_rdy        (alloc_rdy),
    .alloc_line_vld   (alloc_line_vld),
    .alloc_hit        (alloc_hit),
    .alloc_way        (alloc_way),
    .alloc_addr       (alloc_addr),
    .alloc_index      (alloc_index),
    .alloc_txnid      (alloc_txnid),
    .alloc_pref       (alloc_pref),
    .alloc_hzd_bitmap (alloc_hzd_bitmap),
    .v_release_en     (v_release_en),
    .entry_active     (entry_active),
    .txreq_vld        (txreq_vld),
    .txreq_rdy        (txreq_rdy),
    .txreq_line       (txreq_line),
    .txreq_addr       (txreq_addr),
    .txreq_txnid      (txreq_txnid),
    .linefill_done    (linefill_done),
    .rd_vld           (rd_vld),
    .rd_rdy           (rd_rdy),
    .rd_line_vld      (rd_line_vld),
    .rd_way           (rd_way),
    .rd_index         (rd_index),
    .rd_txnid         (rd_txnid),
    .release_en       (release_en),
    .fill_err         (fill_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [1:0] vld, input logic [1:0] hit, input logic pref,
                          input logic [15:0] hzd, input logic [5:0] txnid);
    alloc_line_vld   = vld;
    alloc_hit        = hit;
    alloc_pref       = pref;
    alloc_hzd_bitmap = hzd;
    alloc_txnid      = txnid;
    alloc_en         = 1'b1;
    step();
    alloc_en         = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_en = 0; alloc_line_vld = 0; alloc_hit = 0; alloc_pref = 0;
    alloc_way = {2'd2, 2'd1}; alloc_addr = {A1, A0}; alloc_index = {8'h22, 8'h11};
    alloc_txnid = 0; alloc_hzd_bitmap = 0; v_release_en = 0;
    txreq_rdy = 0; linefill_done = 0; rd_rdy = 0;
    step(); step();
    chk("rst_alloc_rdy", alloc_rdy, 1);
    chk("rst_active", entry_active, 0);
    chk("rst_txreq_vld", txreq_vld, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_release", release_en, 0);
    chk("rst_fill_err", fill_err, 0);
    rst_n = 1'b1;
    step();

    // 1: both hit, no hazard
    do_alloc(2'b11, 2'b11, 1'b0, 16'h0, 6'd5);
    chk("t1_active", entry_active, 1);
    chk("t1_alloc_rdy", alloc_rdy, 0);
    chk("t1_rd_vld_c1", rd_vld, 0);
    step();
    chk("t1_rd_vld_c2", rd_vld, 1);
    chk("t1_rd_line_vld", rd_line_vld, 2'b11);
    chk("t1_rd_way", rd_way, 4'b1001);
    chk("t1_rd_index", rd_index, 16'h2211);
    chk("t1_rd_txnid", rd_txnid, 5);
    chk("t1_txreq_vld", txreq_vld, 0);
    rd_rdy = 1; step(); rd_rdy = 0;
    chk("t1_release_c3", release_en, 1);
    chk("t1_rd_vld_c3", rd_vld, 0);
    chk("t1_alloc_rdy_c3", alloc_rdy, 0);
    step();
    chk("t1_release_c4", release_en, 0);
    chk("t1_alloc_rdy_c4", alloc_rdy, 1);

    // 2: line0 miss with hazard on entry 3, line1 hit
    do_alloc(2'b11, 2'b10, 1'b0, 16'h0008, 6'd9);
    chk("t2_no_req_c1", txreq_vld, 0);
    step();
    chk("t2_no_req_c2", txreq_vld, 0);
    v_release_en = 8'h08; step(); v_release_en = 0;
    chk("t2_no_req_c3", txreq_vld, 0);
    step();
    chk("t2_req_vld", txreq_vld, 1);
    chk("t2_req_line", txreq_line, 0);
    chk("t2_req_addr", txreq_addr, A0);
    chk("t2_req_txnid", txreq_txnid, 9);
    txreq_rdy = 1; step(); txreq_rdy = 0;
    chk("t2_req_done", txreq_vld, 0);
    linefill_done = 2'b01; step(); linefill_done = 0;
    chk("t2_rd_wait", rd_vld, 0);
    step();
    chk("t2_rd_vld", rd_vld, 1);
    chk("t2_rd_line_vld", rd_line_vld, 2'b11);
    rd_rdy = 1; step(); rd_rdy = 0;
    chk("t2_release", release_en, 1);
    step();

    // 3: both miss, downstream back-pressure, out-of-order dones
    do_alloc(2'b11, 2'b00, 1'b0, 16'h0, 6'd12);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t3_hold_vld", txreq_vld, 1);
      chk("t3_hold_line", txreq_line, 0);
      chk("t3_hold_addr", txreq_addr, A0);
      if (k < 3) step();
    end
    txreq_rdy = 1; step();
    chk("t3_l1_vld", txreq_vld, 1);
    chk("t3_l1_line", txreq_line, 1);
    chk("t3_l1_addr", txreq_addr, A1);
    step(); txreq_rdy = 0;
    chk("t3_req_done", txreq_vld, 0);
    linefill_done = 2'b10; step(); linefill_done = 0;
    chk("t3_wait_l0_a", rd_vld, 0);
    step();
    chk("t3_wait_l0_b", rd_vld, 0);
    linefill_done = 2'b01; step(); linefill_done = 0;
    chk("t3_wait_reg", rd_vld, 0);
    step();
    chk("t3_rd_vld", rd_vld, 1);
    chk("t3_no_txreq", txreq_vld, 0);
    rd_rdy = 1; step(); rd_rdy = 0;
    chk("t3_release", release_en, 1);
    step();

    // 4: prefetch, both miss
    do_alloc(2'b11, 2'b00, 1'b1, 16'h0, 6'd3);
    step();
    txreq_rdy = 1;
    chk("t4_l0_line", txreq_line, 0);
    chk("t4_l0_vld", txreq_vld, 1);
    step();
    chk("t4_l1_line", txreq_line, 1);
    chk("t4_l1_vld", txreq_vld, 1);
    step(); txreq_rdy = 0;
    linefill_done = 2'b11; step(); linefill_done = 0;
    chk("t4_no_rd_a", rd_vld, 0);
    chk("t4_no_rel_a", release_en, 0);
    step();
    chk("t4_release", release_en, 1);
    chk("t4_no_rd_b", rd_vld, 0);
    step();
    chk("t4_release_once", release_en, 0);
    chk("t4_idle", alloc_rdy, 1);
    chk("t4_fill_err", fill_err, 0);

    // 5: spurious done on unsent line1
    do_alloc(2'b11, 2'b00, 1'b0, 16'h0, 6'd7);
    linefill_done = 2'b10; step(); linefill_done = 0;
    chk("t5_fill_err", fill_err, 1);
    chk("t5_req_vld", txreq_vld, 1);
    chk("t5_req_line", txreq_line, 0);
    txreq_rdy = 1; step(); step(); txreq_rdy = 0;
    linefill_done = 2'b01; step();
    chk("t5_still_waits", rd_vld, 0);
    linefill_done = 2'b10; step(); linefill_done = 0;
    chk("t5_still_waits2", rd_vld, 0);
    step();
    chk("t5_rd_vld", rd_vld, 1);
    rd_rdy = 1; step(); rd_rdy = 0;
    chk("t5_release", release_en, 1);
    step();
    chk("t5_err_sticky", fill_err, 1);

    // 6: async reset in WAIT_FILL
    do_alloc(2'b11, 2'b00, 1'b0, 16'h0, 6'd1);
    step();
    txreq_rdy = 1; step(); step(); txreq_rdy = 0;
    chk("t6_in_fill", entry_active, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_active", entry_active, 0);
    chk("t6_async_alloc_rdy", alloc_rdy, 1);
    chk("t6_async_txreq", txreq_vld, 0);
    chk("t6_async_rd", rd_vld, 0);
    chk("t6_async_release", release_en, 0);
    chk("t6_async_fill_err", fill_err, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_release", release_en, 0);
    end
    rst_n = 1'b1;
    step();
    chk("t6_post_idle", alloc_rdy, 1);
    chk("t6_post_release", release_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
